// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RISC_TOY pipeline.
// Resolves rs1/rs2 forwarding from the M and W stages, evaluates the ALU and
// captures the result, store data and control into the EM pipeline register.
// Also raises the combinational load-use interlock request.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EMStall,
    input  logic            EMFlush,
    input  logic [1:0]      SelWB_E,
    input  logic            WEN_E,
    input  logic            DREQ_E,
    input  logic            DRW_E,
    input  logic            Load_E,
    input  logic            RS1Used_E,
    input  logic            RS2Used_E,
    input  logic            Sel1_E,
    input  logic [2:0]      Sel2_E,
    input  logic [3:0]      ALUOP_E,
    input  logic [4:0]      RA0_E,
    input  logic [4:0]      RA1_E,
    input  logic [4:0]      WA_E,
    input  logic [XLEN-1:0] DOUT0_E,
    input  logic [XLEN-1:0] DOUT1_E,
    input  logic [XLEN-1:0] PCADD4_E,
    input  logic [XLEN-1:0] JPC_E,
    input  logic [XLEN-1:0] zeroExt_E,
    input  logic [XLEN-1:0] Iext_E,
    input  logic [XLEN-1:0] shamtExt_E,
    input  logic [4:0]      WA_W,
    input  logic            WEN_W,
    input  logic [XLEN-1:0] WBDATA_W,
    output logic [1:0]      SelWB_M,
    output logic            WEN_M,
    output logic            DREQ_M,
    output logic            DRW_M,
    output logic            Load_M,
    output logic [4:0]      WA_M,
    output logic [XLEN-1:0] ALUOUT_M,
    output logic [XLEN-1:0] STDATA_M,
    output logic [XLEN-1:0] PCADD4_M,
    output logic            LoadUseStall
);

    // Writeback select encodings
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_NEG  = 4'd2;
    localparam logic [3:0] ALU_NOT  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_LSR  = 4'd7;
    localparam logic [3:0] ALU_ASR  = 4'd8;
    localparam logic [3:0] ALU_SHL  = 4'd9;
    localparam logic [3:0] ALU_ROR  = 4'd10;
    localparam logic [3:0] ALU_PASS = 4'd11;

    // EM pipeline register state
    logic [1:0]      selwb_m_r;
    logic            wen_m_r;
    logic            dreq_m_r;
    logic            drw_m_r;
    logic            load_m_r;
    logic [4:0]      wa_m_r;
    logic [XLEN-1:0] aluout_m_r;
    logic [XLEN-1:0] stdata_m_r;
    logic [XLEN-1:0] pcadd4_m_r;

    // Forwarding and datapath
    logic            m_hit0_s;
    logic            m_hit1_s;
    logic            w_hit0_s;
    logic            w_hit1_s;
    logic [XLEN-1:0] m_val_s;
    logic [XLEN-1:0] rs1_fwd_s;
    logic [XLEN-1:0] rs2_fwd_s;
    logic [XLEN-1:0] opa_s;
    logic [XLEN-1:0] opb_s;
    logic [4:0]      shamt_s;
    logic [XLEN-1:0] rot_s;
    logic [XLEN-1:0] alu_res_s;

    // Register 0 is an ordinary register here, so index 0 takes part in matching.
    assign m_hit0_s = RS1Used_E & ~wen_m_r & (wa_m_r == RA0_E);
    assign m_hit1_s = RS2Used_E & ~wen_m_r & (wa_m_r == RA1_E);
    assign w_hit0_s = RS1Used_E & ~WEN_W & (WA_W == RA0_E);
    assign w_hit1_s = RS2Used_E & ~WEN_W & (WA_W == RA1_E);

    // A load in M cannot forward yet; the hazard logic stalls and flushes E.
    assign LoadUseStall = (m_hit0_s | m_hit1_s) & (selwb_m_r == WB_LOAD);

    // Value the M stage can forward: link address for jumps, otherwise ALU result
    always_comb begin
        m_val_s = aluout_m_r;
        if (selwb_m_r == WB_PC4) begin
            m_val_s = pcadd4_m_r;
        end else begin
            m_val_s = aluout_m_r;
        end
    end

    // Forwarding muxes, M stage has priority over W stage
    always_comb begin
        rs1_fwd_s = DOUT0_E;
        rs2_fwd_s = DOUT1_E;
        if (m_hit0_s) begin
            rs1_fwd_s = m_val_s;
        end else if (w_hit0_s) begin
            rs1_fwd_s = WBDATA_W;
        end else begin
            rs1_fwd_s = DOUT0_E;
        end
        if (m_hit1_s) begin
            rs2_fwd_s = m_val_s;
        end else if (w_hit1_s) begin
            rs2_fwd_s = WBDATA_W;
        end else begin
            rs2_fwd_s = DOUT1_E;
        end
    end

    // Operand selection
    always_comb begin
        opa_s = rs1_fwd_s;
        opb_s = {XLEN{1'b0}};
        if (Sel1_E) begin
            opa_s = PCADD4_E;
        end else begin
            opa_s = rs1_fwd_s;
        end
        case (Sel2_E)
            3'd0:    opb_s = rs2_fwd_s;
            3'd1:    opb_s = Iext_E;
            3'd2:    opb_s = zeroExt_E;
            3'd3:    opb_s = shamtExt_E;
            3'd4:    opb_s = JPC_E;
            default: opb_s = {XLEN{1'b0}};
        endcase
    end

    assign shamt_s = opb_s[4:0];
    // Rotate right: shift the doubled word and keep the low half
    assign rot_s   = XLEN'({opa_s, opa_s} >> shamt_s);

    // ALU, all arithmetic wraps modulo 2^XLEN
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (ALUOP_E)
            ALU_ADD:  alu_res_s = opa_s + opb_s;
            ALU_SUB:  alu_res_s = opa_s - opb_s;
            ALU_NEG:  alu_res_s = {XLEN{1'b0}} - opb_s;
            ALU_NOT:  alu_res_s = ~opb_s;
            ALU_AND:  alu_res_s = opa_s & opb_s;
            ALU_OR:   alu_res_s = opa_s | opb_s;
            ALU_XOR:  alu_res_s = opa_s ^ opb_s;
            ALU_LSR:  alu_res_s = opa_s >> shamt_s;
            ALU_ASR:  alu_res_s = $signed(opa_s) >>> shamt_s;
            ALU_SHL:  alu_res_s = opa_s << shamt_s;
            ALU_ROR:  alu_res_s = rot_s;
            ALU_PASS: alu_res_s = opb_s;
            default:  alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // EM pipeline register: reset, then flush (bubble), then stall (hold), then load
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            selwb_m_r  <= WB_ALU;
            wen_m_r    <= 1'b1;
            dreq_m_r   <= 1'b1;
            drw_m_r    <= 1'b0;
            load_m_r   <= 1'b0;
            wa_m_r     <= 5'd0;
            aluout_m_r <= {XLEN{1'b0}};
            stdata_m_r <= {XLEN{1'b0}};
            pcadd4_m_r <= {XLEN{1'b0}};
        end else if (EMFlush) begin
            selwb_m_r  <= WB_ALU;
            wen_m_r    <= 1'b1;
            dreq_m_r   <= 1'b1;
            drw_m_r    <= 1'b0;
            load_m_r   <= 1'b0;
            wa_m_r     <= 5'd0;
            aluout_m_r <= {XLEN{1'b0}};
            stdata_m_r <= {XLEN{1'b0}};
            pcadd4_m_r <= {XLEN{1'b0}};
        end else if (!EMStall) begin
            selwb_m_r  <= SelWB_E;
            wen_m_r    <= WEN_E;
            dreq_m_r   <= DREQ_E;
            drw_m_r    <= DRW_E;
            load_m_r   <= Load_E;
            wa_m_r     <= WA_E;
            aluout_m_r <= alu_res_s;
            stdata_m_r <= rs2_fwd_s;
            pcadd4_m_r <= PCADD4_E;
        end
    end

    assign SelWB_M  = selwb_m_r;
    assign WEN_M    = wen_m_r;
    assign DREQ_M   = dreq_m_r;
    assign DRW_M    = drw_m_r;
    assign Load_M   = load_m_r;
    assign WA_M     = wa_m_r;
    assign ALUOUT_M = aluout_m_r;
    assign STDATA_M = stdata_m_r;
    assign PCADD4_M = pcadd4_m_r;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage with a behavioural
// reference model of the EM register, forwarding and ALU.
module tb_ex_stage;

    localparam int XLEN = 32;

    logic        CLK, RST, EMStall, EMFlush;
    logic [1:0]  SelWB_E;
    logic        WEN_E, DREQ_E, DRW_E, Load_E, RS1Used_E, RS2Used_E, Sel1_E;
    logic [2:0]  Sel2_E;
    logic [3:0]  ALUOP_E;
    logic [4:0]  RA0_E, RA1_E, WA_E, WA_W;
    logic [31:0] DOUT0_E, DOUT1_E, PCADD4_E, JPC_E, zeroExt_E, Iext_E, shamtExt_E;
    logic        WEN_W;
    logic [31:0] WBDATA_W;
    logic [1:0]  SelWB_M;
    logic        WEN_M, DREQ_M, DRW_M, Load_M, LoadUseStall;
    logic [4:0]  WA_M;
    logic [31:0] ALUOUT_M, STDATA_M, PCADD4_M;

    ex_stage #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST), .EMStall(EMStall), .EMFlush(EMFlush),
        .SelWB_E(SelWB_E), .WEN_E(WEN_E), .DREQ_E(DREQ_E), .DRW_E(DRW_E),
        .Load_E(Load_E), .RS1Used_E(RS1Used_E), .RS2Used_E(RS2Used_E),
        .Sel1_E(Sel1_E), .Sel2_E(Sel2_E), .ALUOP_E(ALUOP_E),
        .RA0_E(RA0_E), .RA1_E(RA1_E), .WA_E(WA_E),
        .DOUT0_E(DOUT0_E), .DOUT1_E(DOUT1_E), .PCADD4_E(PCADD4_E), .JPC_E(JPC_E),
        .zeroExt_E(zeroExt_E), .Iext_E(Iext_E), .shamtExt_E(shamtExt_E),
        .WA_W(WA_W), .WEN_W(WEN_W), .WBDATA_W(WBDATA_W),
        .SelWB_M(SelWB_M), .WEN_M(WEN_M), .DREQ_M(DREQ_M), .DRW_M(DRW_M),
        .Load_M(Load_M), .WA_M(WA_M), .ALUOUT_M(ALUOUT_M), .STDATA_M(STDATA_M),
        .PCADD4_M(PCADD4_M), .LoadUseStall(LoadUseStall)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of what the EM register should hold
    logic [1:0]  m_selwb;
    logic        m_wen, m_dreq, m_drw, m_load;
    logic [4:0]  m_wa;
    logic [31:0] m_alu, m_st, m_pc4;

    localparam logic [106:0] RST_EM = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 96'd0};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [106:0] dut_em();
        return {SelWB_M, WEN_M, DREQ_M, DRW_M, Load_M, WA_M, ALUOUT_M, STDATA_M, PCADD4_M};
    endfunction

    function automatic logic [106:0] model_em();
        return {m_selwb, m_wen, m_dreq, m_drw, m_load, m_wa, m_alu, m_st, m_pc4};
    endfunction

    function automatic logic [31:0] fwd_ref(input logic used, input logic [4:0] ra,
                                            input logic [31:0] rf);
        if (used && !m_wen && m_wa == ra) return (m_selwb == 2'd2) ? m_pc4 : m_alu;
        if (used && !WEN_W && WA_W == ra) return WBDATA_W;
        return rf;
    endfunction

    function automatic logic lus_ref();
        return !m_wen && m_selwb == 2'd1 &&
               ((RS1Used_E && m_wa == RA0_E) || (RS2Used_E && m_wa == RA1_E));
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int s;
        s = int'(b % 32'd32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return 32'd0 - b;
            4'd3:  return ~b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return a >> s;
            4'd8:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd9:  return a << s;
            4'd10: return (a >> s) | ((s == 0) ? 32'd0 : (a << (32 - s)));
            4'd11: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        {m_selwb, m_wen, m_dreq, m_drw, m_load, m_wa, m_alu, m_st, m_pc4} = RST_EM;
    endtask

    // Predict the next EM contents from the current inputs, then clock
    task automatic clk_step();
        logic [31:0] a, b, rs2, res;
        logic [106:0] nxt;
        rs2 = fwd_ref(RS2Used_E, RA1_E, DOUT1_E);
        a = Sel1_E ? PCADD4_E : fwd_ref(RS1Used_E, RA0_E, DOUT0_E);
        case (Sel2_E)
            3'd0: b = rs2;
            3'd1: b = Iext_E;
            3'd2: b = zeroExt_E;
            3'd3: b = shamtExt_E;
            3'd4: b = JPC_E;
            default: b = 32'd0;
        endcase
        res = alu_ref(ALUOP_E, a, b);
        if (RST || EMFlush) nxt = RST_EM;
        else if (EMStall) nxt = model_em();
        else nxt = {SelWB_E, WEN_E, DREQ_E, DRW_E, Load_E, WA_E, res, rs2, PCADD4_E};
        @(posedge CLK);
        #1;
        {m_selwb, m_wen, m_dreq, m_drw, m_load, m_wa, m_alu, m_st, m_pc4} = nxt;
    endtask

    task automatic idle_inputs();
        SelWB_E = 2'd0; WEN_E = 1'b1; DREQ_E = 1'b1; DRW_E = 1'b0; Load_E = 1'b0;
        RS1Used_E = 1'b0; RS2Used_E = 1'b0; Sel1_E = 1'b0; Sel2_E = 3'd0; ALUOP_E = 4'd0;
        RA0_E = 5'd0; RA1_E = 5'd0; WA_E = 5'd0; WA_W = 5'd0; WEN_W = 1'b1;
        DOUT0_E = 32'd0; DOUT1_E = 32'd0; PCADD4_E = 32'd0; JPC_E = 32'd0;
        zeroExt_E = 32'd0; Iext_E = 32'd0; shamtExt_E = 32'd0; WBDATA_W = 32'd0;
        EMStall = 1'b0; EMFlush = 1'b0;
    endtask

    task automatic rand_e();
        SelWB_E = 2'($urandom_range(0, 2)); WEN_E = 1'($urandom); DREQ_E = 1'($urandom);
        DRW_E = 1'($urandom); Load_E = 1'($urandom);
        RS1Used_E = 1'($urandom); RS2Used_E = 1'($urandom); Sel1_E = 1'($urandom);
        Sel2_E = 3'($urandom); ALUOP_E = 4'($urandom);
        RA0_E = 5'($urandom_range(0, 3)); RA1_E = 5'($urandom_range(0, 3));
        WA_E = 5'($urandom_range(0, 3)); WA_W = 5'($urandom_range(0, 3));
        WEN_W = 1'($urandom);
        DOUT0_E = $urandom; DOUT1_E = $urandom; PCADD4_E = $urandom; JPC_E = $urandom;
        zeroExt_E = $urandom; Iext_E = $urandom; shamtExt_E = $urandom; WBDATA_W = $urandom;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        clk_step();
        rand_e();
        clk_step();
        total++;
        if (dut_em() !== RST_EM) begin
            bad++; $display("FAIL reset_em got=%h want=%h", dut_em(), RST_EM);
        end
        total++;
        if (LoadUseStall !== 1'b0) begin
            bad++; $display("FAIL reset_lus got=%b want=0", LoadUseStall);
        end
        idle_inputs();
        RST = 1'b0;
        clk_step();
    endtask

    task automatic test_add_fwd();
        idle_inputs();
        WEN_E = 1'b0; WA_E = 5'd3; Sel2_E = 3'd1; Iext_E = 32'h10; ALUOP_E = 4'd11;
        clk_step();
        idle_inputs();
        RS1Used_E = 1'b1; RA0_E = 5'd3; DOUT0_E = 32'h99; Sel2_E = 3'd1; Iext_E = 32'd5;
        ALUOP_E = 4'd0;
        clk_step();
        total++;
        if (ALUOUT_M !== 32'h15) begin
            bad++; $display("FAIL add_fwd_m got=%h want=%h", ALUOUT_M, 32'h15);
        end
        total++;
        if (dut_em() !== model_em()) begin
            bad++; $display("FAIL add_fwd_em got=%h want=%h", dut_em(), model_em());
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        WEN_E = 1'b0; WA_E = 5'd7; Sel2_E = 3'd1; Iext_E = 32'hA; ALUOP_E = 4'd11;
        clk_step();
        idle_inputs();
        WEN_E = 1'b1; DREQ_E = 1'b0; DRW_E = 1'b1; WA_E = 5'd7;
        RS2Used_E = 1'b1; RA1_E = 5'd7; DOUT1_E = 32'h55; Sel2_E = 3'd1; Iext_E = 32'h20;
        WA_W = 5'd7; WEN_W = 1'b0; WBDATA_W = 32'hB;
        clk_step();
        total++;
        if (STDATA_M !== 32'hA) begin
            bad++; $display("FAIL prio_m_over_w got=%h want=%h", STDATA_M, 32'hA);
        end
        // M now holds the store (WEN_M=1), so W supplies the value
        clk_step();
        total++;
        if (STDATA_M !== 32'hB) begin
            bad++; $display("FAIL prio_w_only got=%h want=%h", STDATA_M, 32'hB);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        SelWB_E = 2'd1; WEN_E = 1'b0; WA_E = 5'd4; Load_E = 1'b1; DREQ_E = 1'b0;
        clk_step();
        idle_inputs();
        RS2Used_E = 1'b1; RA1_E = 5'd4; RA0_E = 5'd9;
        #1;
        total++;
        if (LoadUseStall !== 1'b1) begin
            bad++; $display("FAIL lus_rs2 got=%b want=1", LoadUseStall);
        end
        RS2Used_E = 1'b0;
        #1;
        total++;
        if (LoadUseStall !== 1'b0) begin
            bad++; $display("FAIL lus_unused got=%b want=0", LoadUseStall);
        end
        RS1Used_E = 1'b1; RA0_E = 5'd4;
        #1;
        total++;
        if (LoadUseStall !== 1'b1) begin
            bad++; $display("FAIL lus_rs1 got=%b want=1", LoadUseStall);
        end
        EMFlush = 1'b1;
        clk_step();
        total++;
        if (dut_em() !== RST_EM) begin
            bad++; $display("FAIL lus_flush got=%h want=%h", dut_em(), RST_EM);
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [4];
        logic [31:0] exp [4];
        ops = '{4'd8, 4'd7, 4'd10, 4'd9};
        exp = '{32'hF800_0000, 32'h0800_0000, 32'h1800_0000, 32'h0000_0010};
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            DOUT0_E = 32'h8000_0001; Sel2_E = 3'd1; Iext_E = 32'd4; ALUOP_E = ops[i];
            clk_step();
            total++;
            if (ALUOUT_M !== exp[i]) begin
                bad++; $display("FAIL shift_op%0d got=%h want=%h", ops[i], ALUOUT_M, exp[i]);
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [106:0] snap;
        idle_inputs();
        WEN_E = 1'b0; DREQ_E = 1'b0; WA_E = 5'd5; Sel2_E = 3'd1; Iext_E = 32'h1234;
        ALUOP_E = 4'd11; PCADD4_E = 32'h400; RS2Used_E = 1'b1; RA1_E = 5'd9;
        DOUT1_E = 32'h77;
        clk_step();
        snap = model_em();
        for (int i = 0; i < 2; i++) begin
            rand_e();
            EMStall = 1'b1;
            clk_step();
            total++;
            if (dut_em() !== snap) begin
                bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, dut_em(), snap);
            end
        end
        rand_e();
        EMStall = 1'b1; EMFlush = 1'b1;
        clk_step();
        total++;
        if ({WEN_M, DREQ_M, ALUOUT_M} !== {1'b1, 1'b1, 32'd0}) begin
            bad++; $display("FAIL stall_flush got=%b%b_%h want=11_00000000",
                            WEN_M, DREQ_M, ALUOUT_M);
        end
        total++;
        if (dut_em() !== model_em()) begin
            bad++; $display("FAIL stall_flush_em got=%h want=%h", dut_em(), model_em());
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        SelWB_E = 2'd1; WEN_E = 1'b0; DREQ_E = 1'b0; DRW_E = 1'b1; Load_E = 1'b1;
        WA_E = 5'd2; Sel2_E = 3'd1; Iext_E = 32'hCAFE; ALUOP_E = 4'd11;
        PCADD4_E = 32'h88; DOUT1_E = 32'h5;
        clk_step();
        idle_inputs();
        RS1Used_E = 1'b1; RA0_E = 5'd2;
        #2 RST = 1'b1;
        #1;
        total++;
        if (dut_em() !== RST_EM) begin
            bad++; $display("FAIL async_rst_em got=%h want=%h", dut_em(), RST_EM);
        end
        total++;
        if (LoadUseStall !== 1'b0) begin
            bad++; $display("FAIL async_rst_lus got=%b want=0", LoadUseStall);
        end
        model_reset();
        #1 RST = 1'b0;
    endtask

    task automatic test_random();
        logic exp_lus;
        for (int i = 0; i < 400; i++) begin
            rand_e();
            EMStall = ($urandom_range(0, 3) == 0);
            EMFlush = ($urandom_range(0, 7) == 0);
            exp_lus = lus_ref();
            if (exp_lus) EMFlush = 1'b1;
            #1;
            total++;
            if (LoadUseStall !== exp_lus) begin
                bad++; $display("FAIL rand_lus_%0d got=%b want=%b", i, LoadUseStall, exp_lus);
            end
            clk_step();
            total++;
            if (dut_em() !== model_em()) begin
                bad++; $display("FAIL rand_em_%0d got=%h want=%h", i, dut_em(), model_em());
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_add_fwd();
        test_priority();
        test_load_use();
        test_shifts();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
